// File: rtl/calc_pkg.sv
// calc_pkg: key codes and entry FSM states shared by the entry and calculation stages.
package calc_pkg;
  localparam logic [4:0] K_ADD  = 5'h0A;
  localparam logic [4:0] K_SUB  = 5'h0B;
  localparam logic [4:0] K_MUL  = 5'h0C;
  localparam logic [4:0] K_DIV  = 5'h0D;
  localparam logic [4:0] K_EQ   = 5'h0E;
  localparam logic [4:0] K_CLR  = 5'h0F;
  localparam logic [4:0] K_BKSP = 5'h10;
  typedef enum logic [2:0] {IDLE, ENT_A, ENT_OP, ENT_B, DONE} state_t;
endpackage

// File: rtl/key_class.sv
// key_class: combinational keypad code classifier; backspace recognised only with EXPR_ENTRY_BACKSPACE_EN.
module key_class
  import calc_pkg::*;
#(
  parameter int KEY_W = 8
) (
  input  logic [KEY_W-1:0] key_code,
  output logic             is_digit,
  output logic             is_op,
  output logic             is_eq,
  output logic             is_clr,
  output logic             is_bksp
);
  assign is_digit = key_code <= KEY_W'(9);
  assign is_op    = key_code >= KEY_W'(K_ADD) && key_code <= KEY_W'(K_DIV);
  assign is_eq    = key_code == KEY_W'(K_EQ);
  assign is_clr   = key_code == KEY_W'(K_CLR);
`ifdef EXPR_ENTRY_BACKSPACE_EN
  assign is_bksp  = key_code == KEY_W'(K_BKSP);
`else
  assign is_bksp  = 1'b0;
`endif
endmodule

// File: rtl/expr_entry.sv
// expr_entry: keypad expression entry FSM (two-digit A op two-digit B =); optional backspace via EXPR_ENTRY_BACKSPACE_EN.
module expr_entry
  import calc_pkg::*;
#(
  parameter int KEY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic [KEY_W-1:0] A1,
  output logic [KEY_W-1:0] A0,
  output logic [KEY_W-1:0] B1,
  output logic [KEY_W-1:0] B0,
  output logic [KEY_W-1:0] OP,
  output logic             done,
  output logic             err
);
  state_t state;
  logic   is_digit, is_op, is_eq, is_clr, is_bksp;

  key_class #(.KEY_W(KEY_W)) u_key_class (
    .key_code(key_code),
    .is_digit(is_digit),
    .is_op(is_op),
    .is_eq(is_eq),
    .is_clr(is_clr),
    .is_bksp(is_bksp)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      A1 <= '0;
      A0 <= '0;
      B1 <= '0;
      B0 <= '0;
      OP <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else if (key_valid) begin
      if (is_clr) begin
        state <= IDLE;
        A1 <= '0;
        A0 <= '0;
        B1 <= '0;
        B0 <= '0;
        OP <= '0;
        done <= 1'b0;
        err <= 1'b0;
      end else
        case (state)
          IDLE:
            if (is_digit) begin
              A1 <= '0;
              A0 <= key_code;
              state <= ENT_A;
            end
          ENT_A:
            if (is_digit) begin
              A1 <= A0;
              A0 <= key_code;
            end else if (is_op) begin
              OP <= key_code;
              state <= ENT_OP;
            end else if (is_bksp) begin
              A0 <= A1;
              A1 <= '0;
            end
          ENT_OP:
            if (is_op)
              OP <= key_code;
            else if (is_digit) begin
              B1 <= '0;
              B0 <= key_code;
              state <= ENT_B;
            end else if (is_bksp) begin
              OP <= '0;
              state <= ENT_A;
            end
          ENT_B:
            if (is_digit) begin
              B1 <= B0;
              B0 <= key_code;
            end else if (is_eq) begin
              done <= 1'b1;
              err <= OP == KEY_W'(K_DIV) && B1 == '0 && B0 == '0;
              state <= DONE;
            end else if (is_bksp) begin
              B0 <= B1;
              B1 <= '0;
            end
          DONE:
            // a digit after a result starts a fresh expression
            if (is_digit) begin
              A1 <= '0;
              A0 <= key_code;
              B1 <= '0;
              B0 <= '0;
              OP <= '0;
              done <= 1'b0;
              err <= 1'b0;
              state <= ENT_A;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_expr_entry.sv
// tb_expr_entry: directed-vector bench for expr_entry; backspace expectations follow EXPR_ENTRY_BACKSPACE_EN.
module tb_expr_entry;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = '0;
  logic [7:0] A1, A0, B1, B0, OP;
  logic       done, err;
  int         n_vec = 0;
  int         n_bad = 0;

  expr_entry #(.KEY_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_code(key_code),
    .A1(A1),
    .A0(A0),
    .B1(B1),
    .B0(B0),
    .OP(OP),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive on the falling edge so the DUT samples cleanly at the next rising edge
  task automatic press(input logic [7:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code = 8'hFF;
  endtask

  task automatic keys(input logic [7:0] k[]);
    foreach (k[i]) press(k[i]);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] a1, a0, b1, b0, op, input logic d, e);
    chk({tag, ".A1"}, A1, a1);
    chk({tag, ".A0"}, A0, a0);
    chk({tag, ".B1"}, B1, b1);
    chk({tag, ".B0"}, B0, b0);
    chk({tag, ".OP"}, OP, op);
    chk({tag, ".done"}, {7'd0, done}, {7'd0, d});
    chk({tag, ".err"}, {7'd0, err}, {7'd0, e});
  endtask

  initial begin
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    keys('{8'h04, 8'h02, 8'h0A, 8'h01, 8'h07, 8'h0E});
    chk_all("add42_17", 4, 2, 1, 7, 8'h0A, 1, 0);
    press(8'h0F);
    keys('{8'h01, 8'h02, 8'h03, 8'h0C, 8'h05, 8'h0E});
    chk_all("mul123_5", 2, 3, 0, 5, 8'h0C, 1, 0);
    press(8'h0F);
    keys('{8'h09, 8'h0D, 8'h00, 8'h0E});
    chk_all("div9_0", 0, 9, 0, 0, 8'h0D, 1, 1);
    press(8'h06);
    chk_all("restart6", 0, 6, 0, 0, 0, 0, 0);
    press(8'h0F);
    keys('{8'h05, 8'h0B, 8'h0A, 8'h03, 8'h0E});
    chk_all("opover", 0, 5, 0, 3, 8'h0A, 1, 0);
    press(8'h0F);
    press(8'h0E);
    chk_all("eq_idle", 0, 0, 0, 0, 0, 0, 0);
    press(8'h10);
    chk_all("bksp_idle", 0, 0, 0, 0, 0, 0, 0);
    keys('{8'h08, 8'h0A});
    chk_all("pre_rst", 0, 8, 0, 0, 8'h0A, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    keys('{8'h03, 8'h0A, 8'h04, 8'h0B});
    chk_all("entb_opign", 0, 3, 0, 4, 8'h0A, 0, 0);
    press(8'h0F);
    chk_all("clr_entb", 0, 0, 0, 0, 0, 0, 0);
    press(8'h0E);
    press(8'h02);
    chk_all("idle_after_clr", 0, 2, 0, 0, 0, 0, 0);
    press(8'h0F);
    keys('{8'h04, 8'h07, 8'h10});
`ifdef EXPR_ENTRY_BACKSPACE_EN
    chk_all("bksp_a", 0, 4, 0, 0, 0, 0, 0);
    keys('{8'h0C, 8'h10});
    chk_all("bksp_op", 0, 4, 0, 0, 0, 0, 0);
`else
    chk_all("bksp_a", 4, 7, 0, 0, 0, 0, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
